// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared constants and state type for the bus-to-UART response bridge
package bridge_pkg;

  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int READ_LEN  = 7;
  localparam int WRITE_LEN = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic logic [2:0] last_index(input logic is_write);
    return is_write ? 3'(WRITE_LEN - 1) : 3'(READ_LEN - 1);
  endfunction

endpackage

// File: rtl/hex_to_ascii.sv
// rtl/hex_to_ascii.sv - combinational nibble to ASCII hex digit, case chosen by HEX_UPPER
module hex_to_ascii #(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'd0, nibble};
    end else begin
      // Offset so that nibble 10 lands on 'A' (0x41) or 'a' (0x61)
      ascii = (HEX_UPPER ? 8'h37 : 8'h57) + {4'd0, nibble};
    end
  end

endmodule

// File: rtl/bridge_tx.sv
// rtl/bridge_tx.sv - formats bus read responses as "Mhhhh\r\n" for a UART; write acks when BRIDGE_TX_WRITE_ACK_EN
module bridge_tx
  import bridge_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        overrun_o
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] act_data_q, act_data_d;
  logic        act_wr_q, act_wr_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        pend_wr_q, pend_wr_d;
  logic        overrun_q, overrun_d;

  logic        beat;
  logic        beat_wr;
  logic        xfer;
  logic        last;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic        unused_addr;

  assign unused_addr = ^addr_i;

`ifdef BRIDGE_TX_WRITE_ACK_EN
  assign beat    = valid_i;
  assign beat_wr = rw_i;
`else
  assign beat    = valid_i && !rw_i;
  assign beat_wr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      act_data_q   <= 16'd0;
      act_wr_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 16'd0;
      pend_wr_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_wr_q     <= act_wr_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_wr_q    <= pend_wr_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_wr_d     = act_wr_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_wr_d    = pend_wr_q;
    overrun_d    = overrun_q;
    xfer         = (state_q == ST_SEND) && tx_ready_i;
    last         = xfer && (idx_q == last_index(act_wr_q));

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          state_d    = ST_SEND;
          idx_d      = 3'd0;
          act_data_d = data_i;
          act_wr_d   = beat_wr;
        end
      end
      ST_SEND: begin
        if (last) begin
          idx_d = 3'd0;
          if (pend_valid_q) begin
            // Slot drains this edge, so a coincident beat refills it rather than overrunning
            act_data_d   = pend_data_q;
            act_wr_d     = pend_wr_q;
            pend_valid_d = beat;
            if (beat) begin
              pend_data_d = data_i;
              pend_wr_d   = beat_wr;
            end
          end else if (beat) begin
            act_data_d = data_i;
            act_wr_d   = beat_wr;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + 3'd1;
          end
          if (beat) begin
            if (!pend_valid_q) begin
              pend_valid_d = 1'b1;
              pend_data_d  = data_i;
              pend_wr_d    = beat_wr;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd1:    nibble = act_data_q[15:12];
      3'd2:    nibble = act_data_q[11:8];
      3'd3:    nibble = act_data_q[7:4];
      default: nibble = act_data_q[3:0];
    endcase
  end

  hex_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_hex (
    .nibble(nibble),
    .ascii (hex_char)
  );

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == ST_SEND) begin
      if (act_wr_q) begin
        case (idx_q)
          3'd0:    tx_data_o = ASCII_M;
          3'd1:    tx_data_o = ASCII_CR;
          default: tx_data_o = ASCII_LF;
        endcase
      end else begin
        case (idx_q)
          3'd0:                   tx_data_o = ASCII_M;
          3'd1, 3'd2, 3'd3, 3'd4: tx_data_o = hex_char;
          3'd5:                   tx_data_o = ASCII_CR;
          default:                tx_data_o = ASCII_LF;
        endcase
      end
    end
  end

  assign tx_valid_o = (state_q == ST_SEND);
  assign overrun_o  = overrun_q;

endmodule

// File: doc/bridge_tx.md
BRIDGE_TX -- requirements
Module: bridge_tx

Interface
REQ-001 Parameter HEX_UPPER, default 1: 1 emits hex digits A-F as uppercase ASCII, 0 emits them as lowercase.
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 addr_i  input  16  bus address from the last memory in the chain; ignored except for bus continuity.
REQ-006 data_i  input  16  bus data; holds read result when rw_i=0.
REQ-007 rw_i  input  1  0=read response, 1=write.
REQ-008 valid_i  input  1  bus beat qualifier, one-cycle pulse per transaction.
REQ-009 tx_data_o  output  8  ASCII byte to UART transmitter.
REQ-010 tx_valid_o  output  1  tx_data_o holds a byte awaiting acceptance.
REQ-011 tx_ready_i  input  1  UART transmitter accepts the byte this cycle.
REQ-012 overrun_o  output  1  sticky flag: a response was dropped.

Function
REQ-013 A read beat (valid_i=1, rw_i=0) produces 7 bytes: 'M', then four hex digits of data_i MSB nibble first, then 0x0D, then 0x0A.
REQ-014 A write beat without BRIDGE_TX_WRITE_ACK_EN produces no bytes and no state change.
REQ-015 A byte transfers on a rising edge where tx_valid_o=1 and tx_ready_i=1; tx_data_o and tx_valid_o hold stable until then.
REQ-016 States: IDLE (tx_valid_o=0) and SEND (tx_valid_o=1, 3-bit byte index 0..6).
REQ-017 IDLE->SEND on the edge capturing a response beat; first byte 'M' appears on tx_data_o the following cycle (latency 1).
REQ-018 In SEND, each transfer increments the byte index; transfer of the last byte returns to IDLE unless a pending response exists.
REQ-019 One pending slot captures a response beat arriving while in SEND.
REQ-020 When the last byte transfers and the pending slot is full, the pending response loads into the active register on the same edge; tx_valid_o stays 1 with 'M' (no idle gap).
REQ-021 When the last byte transfers, the pending slot is empty, and a beat arrives on that edge, the beat loads directly into the active register.
REQ-022 A beat arriving while the pending slot is full and not being drained is dropped and sets overrun_o=1.
REQ-023 overrun_o clears only on reset.
REQ-024 Hex conversion: nibble 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 (HEX_UPPER=1) or 0x61-0x66 (HEX_UPPER=0).

Reset
REQ-025 While rst_n=0: tx_valid_o=0, tx_data_o=0x00, overrun_o=0, state IDLE, byte index 0, pending slot empty.
REQ-026 Reset asserted mid-response aborts it immediately; no further bytes of that response are emitted after reset release.

Configuration
REQ-027 Macro BRIDGE_TX_WRITE_ACK_EN: when defined, a write beat produces the 3 bytes 'M', 0x0D, 0x0A, using the same queuing, pending, and overrun rules as reads.
REQ-028 When BRIDGE_TX_WRITE_ACK_EN is undefined, write beats are ignored (REQ-014) and no acknowledge logic is synthesised.

Structure
REQ-029 Shared package bridge_pkg holds ASCII constants (M, CR, LF), the response-length localparams (7 for reads, 3 for writes), and the state enum type.
REQ-030 One sub-module, hex_to_ascii (4-bit nibble -> 8-bit ASCII, combinational, HEX_UPPER parameter), instantiated once on the selected nibble.

Verification
REQ-031 Read beat with data_i=0x0012 and tx_ready_i tied to 1 -> bytes 0x4D,0x30,0x30,0x31,0x32,0x0D,0x0A on 7 consecutive cycles, starting 1 cycle after the beat.
REQ-032 Read beat with data_i=0xBEEF, HEX_UPPER=0, and tx_ready_i toggling 1/0 -> "Mbeef\r\n" emitted, each byte held stable while tx_ready_i=0.
REQ-033 Write beat with data_i=0x0069 -> macro off: no tx_valid_o for 20 cycles; macro on: "M\r\n".
REQ-034 Two read beats (0x0001 then 0x000A) 2 cycles apart with tx_ready_i=1 -> "M0001\r\nM000A\r\n" with no gap between them; overrun_o stays 0.
REQ-035 Three read beats on consecutive cycles while tx_ready_i=0 -> third beat dropped, overrun_o=1; after tx_ready_i=1, only the first two responses are emitted.
REQ-036 rst_n driven low after the 3rd byte of a read response -> tx_valid_o=0 immediately and overrun_o=0; after release, a new read of 0x0003 emits "M0003\r\n" cleanly.
